nbit_mosi_spi_rx: RTL and testbench

NBIT_MOSI_SPI_RX -- requirements
Module: nbit_mosi_spi_rx

---
 rtl/nbit_mosi_spi_rx_pkg.sv | 22 ++
 rtl/nbit_mosi_spi_rx_if.sv | 50 +++++
 rtl/spi_sat_counter.sv | 36 +++
 rtl/nbit_mosi_spi_rx.sv | 131 +++++++++++++
 tb/tb_nbit_mosi_spi_rx.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/nbit_mosi_spi_rx_pkg.sv
// Shared SPI definitions for the MOSI transmit and receive blocks: FSM state
// encoding, default word geometry and a sizing helper for the bit counter.
package nbit_mosi_spi_rx_pkg;

    // Default bits per serial word.
    localparam int unsigned SPI_DEFAULT_WIDTH = 8;

    // Default width of the completed-word counters.
    localparam int unsigned SPI_DEFAULT_CNT_W = 8;

    // Two-state framing machine; encodings are shared with the transmitter.
    typedef enum logic {
        StIdle    = 1'b0,
        StReceive = 1'b1
    } spi_state_e;

    // Bit counter must hold the values 0..width inclusive.
    function automatic int unsigned spi_bit_cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/nbit_mosi_spi_rx_if.sv
// Bus bundle between an SPI MOSI source and the word receiver. The master
// side drives the serial lines; the slave side returns the framed words.
interface nbit_mosi_spi_rx_if
    import nbit_mosi_spi_rx_pkg::*;
#(
    parameter int unsigned WIDTH = SPI_DEFAULT_WIDTH,
    parameter int unsigned CNT_W = SPI_DEFAULT_CNT_W
);

    // Serial side
    logic             i_MOSI;
    logic             i_CS;
    logic             i_DC;

    // Word side
    logic [WIDTH-1:0] o_DATA;
    logic             o_DC;
    logic             o_VALID;
    logic             o_ABORT;
    logic             o_BUSY;
    logic [CNT_W-1:0] o_CMD_CNT;
    logic [CNT_W-1:0] o_DATA_CNT;

    modport master (
        output i_MOSI,
        output i_CS,
        output i_DC,
        input  o_DATA,
        input  o_DC,
        input  o_VALID,
        input  o_ABORT,
        input  o_BUSY,
        input  o_CMD_CNT,
        input  o_DATA_CNT
    );

    modport slave (
        input  i_MOSI,
        input  i_CS,
        input  i_DC,
        output o_DATA,
        output o_DC,
        output o_VALID,
        output o_ABORT,
        output o_BUSY,
        output o_CMD_CNT,
        output o_DATA_CNT
    );

endinterface

// File: rtl/spi_sat_counter.sv
// Saturating up-counter used to tally completed SPI words. Once the count
// reaches all-ones it stays there until reset.
module spi_sat_counter
    import nbit_mosi_spi_rx_pkg::*;
#(
    parameter int unsigned CNT_W = SPI_DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: step on request unless already pinned at the maximum.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/nbit_mosi_spi_rx.sv
// N-bit SPI MOSI word receiver. Bits arrive MSB first on rising i_SCK edges
// while CS is low; every WIDTH bits form a word that is presented on o_DATA
// together with the D/C qualifier sampled on its last bit. CS rising inside a
// word drops the partial word and pulses o_ABORT. Words are framed purely by
// the bit count, so CS may stay low across back-to-back words.
// WIDTH is expected to lie in 2..32.
module nbit_mosi_spi_rx
    import nbit_mosi_spi_rx_pkg::*;
#(
    parameter int unsigned WIDTH = SPI_DEFAULT_WIDTH,
    parameter int unsigned CNT_W = SPI_DEFAULT_CNT_W
) (
    input  logic              i_SCK,
    input  logic              i_RST,
    nbit_mosi_spi_rx_if.slave bus
);

    localparam int unsigned BitCntW = spi_bit_cnt_w(WIDTH);

    // Count value before the sample that completes a word.
    localparam logic [BitCntW-1:0] CntLast = BitCntW'(WIDTH - 1);
    localparam logic [BitCntW-1:0] CntOne  = BitCntW'(1);

    spi_state_e         state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [BitCntW-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic               dc_q,    dc_d;
    logic               valid_q, valid_d;
    logic               abort_q, abort_d;
    logic               inc_cmd;
    logic               inc_data;

    // Next-state, word capture and strobe generation for the framing FSM.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        dc_d     = dc_q;
        valid_d  = 1'b0;
        abort_d  = 1'b0;
        inc_cmd  = 1'b0;
        inc_data = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!bus.i_CS) begin
                    // First bit of a word; it ends up as the MSB after the
                    // remaining WIDTH-1 left shifts.
                    shift_d = {{(WIDTH-1){1'b0}}, bus.i_MOSI};
                    cnt_d   = CntOne;
                    state_d = StReceive;
                end
            end

            StReceive: begin
                if (bus.i_CS) begin
                    // CS released mid-word: drop the partial word.
                    shift_d = '0;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                    state_d = StIdle;
                end else if (cnt_q == CntLast) begin
                    // LSB sample completes the word on this same edge.
                    shift_d  = {shift_q[WIDTH-2:0], bus.i_MOSI};
                    cnt_d    = cnt_q + CntOne;
                    data_d   = {shift_q[WIDTH-2:0], bus.i_MOSI};
                    dc_d     = bus.i_DC;
                    valid_d  = 1'b1;
                    inc_cmd  = ~bus.i_DC;
                    inc_data = bus.i_DC;
                    state_d  = StIdle;
                end else begin
                    shift_d = {shift_q[WIDTH-2:0], bus.i_MOSI};
                    cnt_d   = cnt_q + CntOne;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, shift register, word holding register and one-cycle strobes.
    always_ff @(posedge i_SCK or negedge i_RST) begin
        if (!i_RST) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            dc_q    <= 1'b0;
            valid_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            dc_q    <= dc_d;
            valid_q <= valid_d;
            abort_q <= abort_d;
        end
    end

    spi_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cmd_cnt (
        .clk   (i_SCK),
        .rst_n (i_RST),
        .inc   (inc_cmd),
        .count (bus.o_CMD_CNT)
    );

    spi_sat_counter #(
        .CNT_W (CNT_W)
    ) u_data_cnt (
        .clk   (i_SCK),
        .rst_n (i_RST),
        .inc   (inc_data),
        .count (bus.o_DATA_CNT)
    );

    assign bus.o_DATA  = data_q;
    assign bus.o_DC    = dc_q;
    assign bus.o_VALID = valid_q;
    assign bus.o_ABORT = abort_q;
    assign bus.o_BUSY  = (state_q == StReceive);

endmodule

// File: tb/tb_nbit_mosi_spi_rx.sv
// Bench for the SPI MOSI word receiver. Two instances share one serial
// stream: an 8-bit receiver with 8-bit counters and a 16-bit receiver with
// 2-bit counters. A bit-accumulating reference model predicts every output
// of both after each rising edge; directed scenarios are followed by a
// random stream.
module tb_nbit_mosi_spi_rx;

    logic sck;
    logic rst;

    int n_tests;
    int n_fail;

    nbit_mosi_spi_rx_if #(.WIDTH(8),  .CNT_W(8)) bus8  ();
    nbit_mosi_spi_rx_if #(.WIDTH(16), .CNT_W(2)) bus16 ();

    nbit_mosi_spi_rx #(
        .WIDTH (8),
        .CNT_W (8)
    ) u_dut8 (
        .i_SCK (sck),
        .i_RST (rst),
        .bus   (bus8)
    );

    nbit_mosi_spi_rx #(
        .WIDTH (16),
        .CNT_W (2)
    ) u_dut16 (
        .i_SCK (sck),
        .i_RST (rst),
        .bus   (bus16)
    );

    initial sck = 1'b0;
    always #5 sck = ~sck;

    // Reference model state, index 0 = 8-bit instance, 1 = 16-bit instance
    int          m_w    [2] = '{8, 16};
    int          m_cmax [2] = '{255, 3};
    int          m_bits [2];
    logic [31:0] m_acc  [2];
    logic [31:0] m_data [2];
    logic        m_dc   [2];
    logic        m_valid[2];
    logic        m_abort[2];
    int          m_cmd  [2];
    int          m_dcnt [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_bits[k]  = 0;
            m_acc[k]   = '0;
            m_data[k]  = '0;
            m_dc[k]    = 1'b0;
            m_valid[k] = 1'b0;
            m_abort[k] = 1'b0;
            m_cmd[k]   = 0;
            m_dcnt[k]  = 0;
        end
    endtask

    // One sampled edge: collect bits until the word length is reached.
    task automatic model_step(input logic cs, input logic mosi, input logic dc);
        for (int k = 0; k < 2; k++) begin
            logic [31:0] mask;
            mask       = (32'h1 << m_w[k]) - 32'h1;
            m_valid[k] = 1'b0;
            m_abort[k] = 1'b0;
            if (!cs) begin
                m_acc[k]  = (m_acc[k] << 1) | {31'b0, mosi};
                m_bits[k] = m_bits[k] + 1;
                if (m_bits[k] == m_w[k]) begin
                    m_data[k]  = m_acc[k] & mask;
                    m_dc[k]    = dc;
                    m_valid[k] = 1'b1;
                    if (dc) begin
                        if (m_dcnt[k] < m_cmax[k]) m_dcnt[k] = m_dcnt[k] + 1;
                    end else begin
                        if (m_cmd[k] < m_cmax[k]) m_cmd[k] = m_cmd[k] + 1;
                    end
                    m_bits[k] = 0;
                    m_acc[k]  = '0;
                end
            end else if (m_bits[k] > 0) begin
                m_abort[k] = 1'b1;
                m_bits[k]  = 0;
                m_acc[k]   = '0;
            end
        end
    endtask

    task automatic compare_all();
        check("data8",   32'(bus8.o_DATA),      m_data[0]);
        check("dc8",     32'(bus8.o_DC),        32'(m_dc[0]));
        check("valid8",  32'(bus8.o_VALID),     32'(m_valid[0]));
        check("abort8",  32'(bus8.o_ABORT),     32'(m_abort[0]));
        check("busy8",   32'(bus8.o_BUSY),      32'(m_bits[0] > 0));
        check("cmd8",    32'(bus8.o_CMD_CNT),   32'(m_cmd[0]));
        check("dcnt8",   32'(bus8.o_DATA_CNT),  32'(m_dcnt[0]));
        check("data16",  32'(bus16.o_DATA),     m_data[1]);
        check("dc16",    32'(bus16.o_DC),       32'(m_dc[1]));
        check("valid16", 32'(bus16.o_VALID),    32'(m_valid[1]));
        check("abort16", 32'(bus16.o_ABORT),    32'(m_abort[1]));
        check("busy16",  32'(bus16.o_BUSY),     32'(m_bits[1] > 0));
        check("cmd16",   32'(bus16.o_CMD_CNT),  32'(m_cmd[1]));
        check("dcnt16",  32'(bus16.o_DATA_CNT), 32'(m_dcnt[1]));
    endtask

    // Called at a falling edge: drive, take the rising edge, check at the
    // following falling edge.
    task automatic tick(input logic cs, input logic mosi, input logic dc);
        bus8.i_CS    = cs;
        bus8.i_MOSI  = mosi;
        bus8.i_DC    = dc;
        bus16.i_CS   = cs;
        bus16.i_MOSI = mosi;
        bus16.i_DC   = dc;
        @(posedge sck);
        model_step(cs, mosi, dc);
        @(negedge sck);
        compare_all();
    endtask

    task automatic send_word(input int nbits, input logic [31:0] w, input logic dc);
        for (int i = nbits - 1; i >= 0; i--) begin
            tick(1'b0, w[i], dc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        rst          = 1'b0;
        bus8.i_CS    = 1'b1;
        bus8.i_MOSI  = 1'b0;
        bus8.i_DC    = 1'b0;
        bus16.i_CS   = 1'b1;
        bus16.i_MOSI = 1'b0;
        bus16.i_DC   = 1'b0;
        #1;
        compare_all();
        @(negedge sck);
        rst = 1'b1;

        // Idle edges with CS high change nothing
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0);

        // Single command word
        send_word(8, 32'hA5, 1'b0);
        check("a5_valid", 32'(bus8.o_VALID),   32'h1);
        check("a5_data",  32'(bus8.o_DATA),    32'hA5);
        check("a5_cmd",   32'(bus8.o_CMD_CNT), 32'h1);

        // Back-to-back data words, CS held low
        send_word(8, 32'h3C, 1'b1);
        check("3c_data", 32'(bus8.o_DATA), 32'h3C);
        send_word(8, 32'hC3, 1'b1);
        check("c3_data", 32'(bus8.o_DATA),     32'hC3);
        check("c3_dcnt", 32'(bus8.o_DATA_CNT), 32'h2);

        // Abort after 5 bits
        send_word(5, 32'h1F, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        check("abort_pulse", 32'(bus8.o_ABORT),    32'h1);
        check("abort_hold",  32'(bus8.o_DATA),     32'hC3);
        check("abort_dcnt",  32'(bus8.o_DATA_CNT), 32'h2);
        tick(1'b1, 1'b0, 1'b0);
        check("abort_clear", 32'(bus8.o_ABORT), 32'h0);
        send_word(8, 32'h12, 1'b1);
        check("12_data", 32'(bus8.o_DATA), 32'h12);

        // Reset after 3 bits
        send_word(3, 32'h5, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_abort", 32'(bus8.o_ABORT), 32'h0);
        check("rst_busy",  32'(bus8.o_BUSY),  32'h0);
        @(negedge sck);
        rst = 1'b1;
        send_word(8, 32'h81, 1'b0);
        check("81_data", 32'(bus8.o_DATA),    32'h81);
        check("81_cmd",  32'(bus8.o_CMD_CNT), 32'h1);

        // Realign the 16-bit receiver, then stream two 16-bit data words
        tick(1'b1, 1'b0, 1'b0);
        send_word(16, 32'hBEEF, 1'b1);
        check("beef_data", 32'(bus16.o_DATA), 32'hBEEF);
        check("beef_dc",   32'(bus16.o_DC),   32'h1);
        send_word(16, 32'h0001, 1'b1);
        check("0001_data", 32'(bus16.o_DATA), 32'h0001);
        check("0001_dcnt", 32'(bus16.o_DATA_CNT), 32'h2);

        // Five command words saturate the 2-bit counter
        for (int n = 0; n < 5; n++) begin
            send_word(16, 32'(16'h1000 + n), 1'b0);
        end
        check("sat_cmd16", 32'(bus16.o_CMD_CNT), 32'h3);

        // Random stream with occasional CS release
        for (int n = 0; n < 1000; n++) begin
            tick(($urandom_range(0, 24) == 0), 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
